ldl_hist_servicer: RTL and testbench
====================================

LDL_HIST_SERVICER -- requirements
Module: LDL_hist_servicer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of event lines (2..64).
REQ-002 SHALL have derived parameter IDXW, default $clog2(WIDTH), index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low (0 is reset).
REQ-005 SHALL have port clr  input  1  synchronous clear of all pending/overflow state (1 is clear).
REQ-006 SHALL have port en  input  1  permits new grants when 1.
REQ-007 SHALL have port x  input  WIDTH  event pulses, sampled every cycle.
REQ-008 SHALL have port out_valid  output  1  an index is offered for service.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the offered index.
REQ-010 SHALL have port out_idx  output  IDXW  offered event line number.
REQ-011 SHALL have port pend  output  WIDTH  sticky pending bits, registered.
REQ-012 SHALL have port ovf  output  WIDTH  sticky overflow bits, registered.

Function
REQ-013 SHALL update pend[i] each edge: set if x[i]=1; cleared only by service of i (REQ-019) or clr.
REQ-014 SHALL set ovf[i] when x[i]=1 while pend[i] is already 1 and line i is not being serviced that edge; ovf clears only by clr or reset.
REQ-015 SHALL implement FSM states IDLE and GRANT.
REQ-016 SHALL, in IDLE with en=1, clr=0 and |pend=1, select the first set bit of registered pend, searching upward from pointer ptr with wrap WIDTH-1->0, register it into out_idx and enter GRANT.
REQ-017 SHALL drive out_valid=1 exactly in GRANT; first assertion one cycle after the selecting IDLE cycle (event-to-valid latency 2 cycles from x pulse).
REQ-018 SHALL hold out_idx and out_valid stable in GRANT until out_valid&out_ready.
REQ-019 SHALL, on handshake, clear pend[out_idx], set ptr=(out_idx+1) mod WIDTH and return to IDLE; maximum throughput one service per 2 cycles.
REQ-020 SHALL, if x[out_idx]=1 in the handshake cycle, keep pend[out_idx]=1 (set wins) and not set ovf[out_idx].
REQ-021 SHALL let a GRANT in progress complete when en falls; en affects only IDLE->GRANT.
REQ-022 SHALL, on clr=1, clear pend, ovf, ptr to 0 and force IDLE next edge; clr has priority over x and handshake in the same cycle; an active grant is aborted (out_valid=0 next cycle).
REQ-023 SHALL treat out_ready outside GRANT as don't-care.
REQ-024 SHALL never offer an index whose pend bit is 0 at the time of selection.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force pend=0, ovf=0, ptr=0, out_idx=0, out_valid=0, state IDLE.
REQ-026 SHALL resume sampling x on the first rising clk after rst_n deasserts; no event is inferred across reset.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, GRANT) in shared package LDL_hist_pkg.
REQ-028 SHALL instantiate one combinational sub-module LDL_rr_pick (WIDTH-bit request, IDXW-bit pointer in; found flag and index out).
REQ-029 SHALL keep all registers in LDL_hist_servicer; LDL_rr_pick holds no state.

Verification
REQ-030 Reset: rst_n=0 mid-GRANT with pend=8'h05 -> out_valid=0, pend=0, ovf=0 immediately, before next edge.
REQ-031 Round-robin: WIDTH=8, x=8'h81 one cycle, en=1, out_ready=1 -> out_idx 0 then 7, grants 2 cycles apart, pend ends 8'h00, ptr=0.
REQ-032 Backpressure: x=8'h10, out_ready=0 for 5 cycles -> out_valid held 5 cycles with out_idx=4; ready=1 -> pend=0 next edge.
REQ-033 Overflow: x[3] pulsed twice while out_ready=0 -> ovf=8'h08; x[3] coincident with handshake of 3 -> pend[3] stays 1, ovf unchanged, idx 3 reoffered.
REQ-034 Clear: clr=1 during GRANT with x=8'hFF same cycle -> next edge pend=0, ovf=0, out_valid=0, ptr=0.
REQ-035 Enable: en=0 with pend=8'h22 -> no out_valid for 10 cycles; en=1 -> out_idx=1 two cycles later, then 5.

Source files
------------

// File: rtl/ldl_hist_pkg.sv
// Shared types for the event-history servicer: FSM state encoding.
package ldl_hist_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/ldl_rr_pick.sv
// Round-robin first-set search over a request vector, starting at ptr and wrapping.
module ldl_rr_pick #(
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IDXW-1:0]  ptr,
   output logic             found,
   output logic [IDXW-1:0]  idx
);

   int j;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= WIDTH) j = j - WIDTH;
         if (req[j]) begin
            found = 1'b1;
            idx   = IDXW'(j);
         end
      end
   end

endmodule

// File: rtl/ldl_hist_servicer.sv
// Sticky event capture with overflow tracking and a round-robin valid/ready servicer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no offer; picks next pending line when en=1 and any pend
//   GRANT | out_idx offered with out_valid=1 until out_ready handshake
module ldl_hist_servicer
   import ldl_hist_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic [WIDTH-1:0] pend,
   output logic [WIDTH-1:0] ovf
);

   state_t            state;
   logic [IDXW-1:0]   ptr;
   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;
   logic              hs;
   logic [WIDTH-1:0]  svc_mask;
   logic [IDXW-1:0]   ptr_inc;

   ldl_rr_pick #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_pick (
      .req   (pend),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign hs       = (state == GRANT) && out_ready;
   assign svc_mask = hs ? (WIDTH'(1) << out_idx) : '0;
   assign ptr_inc  = (out_idx == IDXW'(WIDTH - 1)) ? '0 : out_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend      <= '0;
         ovf       <= '0;
         ptr       <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
      end else if (clr) begin
         state     <= IDLE;
         pend      <= '0;
         ovf       <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
      end else begin
         // A new pulse on the line being serviced re-arms it without counting as overflow.
         pend <= (pend & ~svc_mask) | x;
         ovf  <= ovf | (x & pend & ~svc_mask);
         case (state)
            IDLE: begin
               if (en && pick_found) begin
                  out_idx   <= pick_idx;
                  out_valid <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  ptr       <= ptr_inc;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldl_hist_servicer.sv
// Directed checks of capture, round-robin service, backpressure, overflow, clear, enable and reset.
module tb_ldl_hist_servicer;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       en;
   logic [7:0] x;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic [7:0] pend;
   logic [7:0] ovf;

   int n_cmp = 0;
   int n_err = 0;

   ldl_hist_servicer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .en        (en),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pend      (pend),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; x = 8'h00; out_ready = 1'b0;
      #3;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_pend",  32'(pend),      32'h00);
      chk("rst_ovf",   32'(ovf),       32'h00);
      chk("rst_idx",   32'(out_idx),   32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Round-robin: lines 0 and 7 together
      en = 1'b1; out_ready = 1'b1; x = 8'h81;
      tick();
      x = 8'h00;
      chk("rr_pend_cap",  32'(pend),      32'h81);
      chk("rr_lat_valid", 32'(out_valid), 32'h0);
      tick();
      chk("rr_v0",   32'(out_valid), 32'h1);
      chk("rr_idx0", 32'(out_idx),   32'h0);
      tick();
      chk("rr_hs0_pend",  32'(pend),      32'h80);
      chk("rr_hs0_valid", 32'(out_valid), 32'h0);
      tick();
      chk("rr_v7",   32'(out_valid), 32'h1);
      chk("rr_idx7", 32'(out_idx),   32'h7);
      tick();
      chk("rr_end_pend", 32'(pend),    32'h00);
      chk("rr_end_ptr",  32'(dut.ptr), 32'h0);

      // Backpressure on line 4
      out_ready = 1'b0; x = 8'h10;
      tick();
      x = 8'h00;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_idx",   32'(out_idx),   32'h4);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_pend",  32'(pend),      32'h00);
      chk("bp_valid_drop", 32'(out_valid), 32'h0);
      chk("bp_ptr",   32'(dut.ptr),   32'h5);

      // Overflow on line 3; pointer at 5 wraps to 3
      out_ready = 1'b0; x = 8'h08;
      tick();
      x = 8'h00;
      chk("ov_pend1", 32'(pend), 32'h08);
      chk("ov_ovf1",  32'(ovf),  32'h00);
      tick();
      chk("ov_v3",   32'(out_valid), 32'h1);
      chk("ov_idx3", 32'(out_idx),   32'h3);
      x = 8'h08;
      tick();
      x = 8'h00;
      chk("ov_ovf2", 32'(ovf), 32'h08);
      x = 8'h08; out_ready = 1'b1;
      tick();
      x = 8'h00;
      chk("ov_hs_pend",  32'(pend),      32'h08);
      chk("ov_hs_ovf",   32'(ovf),       32'h08);
      chk("ov_hs_valid", 32'(out_valid), 32'h0);
      tick();
      out_ready = 1'b0;
      chk("ov_reoffer_v",   32'(out_valid), 32'h1);
      chk("ov_reoffer_idx", 32'(out_idx),   32'h3);

      // Clear during grant beats x and handshake
      clr = 1'b1; x = 8'hFF; out_ready = 1'b1;
      tick();
      clr = 1'b0; x = 8'h00; out_ready = 1'b0;
      chk("clr_pend",  32'(pend),      32'h00);
      chk("clr_ovf",   32'(ovf),       32'h00);
      chk("clr_valid", 32'(out_valid), 32'h0);
      chk("clr_ptr",   32'(dut.ptr),   32'h0);
      tick();
      chk("clr_idle_valid", 32'(out_valid), 32'h0);

      // Enable gating with pend = 8'h22
      en = 1'b0; x = 8'h22;
      tick();
      x = 8'h00;
      chk("en_pend", 32'(pend), 32'h22);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("en_hold_valid", 32'(out_valid), 32'h0);
      end
      en = 1'b1;
      tick();
      chk("en_v1",   32'(out_valid), 32'h1);
      chk("en_idx1", 32'(out_idx),   32'h1);
      out_ready = 1'b1;
      tick();
      chk("en_hs1_pend", 32'(pend), 32'h20);
      tick();
      chk("en_v5",   32'(out_valid), 32'h1);
      chk("en_idx5", 32'(out_idx),   32'h5);
      en = 1'b0;
      tick();
      chk("en_fall_hs_pend",  32'(pend),      32'h00);
      chk("en_fall_hs_valid", 32'(out_valid), 32'h0);
      chk("en_fall_ptr",      32'(dut.ptr),   32'h6);

      // Async reset mid-grant with pend = 8'h05
      en = 1'b1; out_ready = 1'b0; x = 8'h05;
      tick();
      x = 8'h00;
      tick();
      chk("ar_v",   32'(out_valid), 32'h1);
      chk("ar_idx", 32'(out_idx),   32'h0);
      x = 8'h05;
      tick();
      x = 8'h00;
      chk("ar_pre_pend", 32'(pend), 32'h05);
      chk("ar_pre_ovf",  32'(ovf),  32'h05);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'h0);
      chk("ar_pend",  32'(pend),      32'h00);
      chk("ar_ovf",   32'(ovf),       32'h00);
      chk("ar_idx0",  32'(out_idx),   32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_post_pend",  32'(pend),      32'h00);
      chk("ar_post_valid", 32'(out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
